// File: rtl/encode83_debounced.sv
// encode83_debounced
// Eight raw switch inputs pass through a two-flop synchronizer and a
// whole-vector debouncer. The highest set bit of the accepted vector is then
// encoded into a 3-bit index and a 4-bit digit code that feeds a BCD
// seven-segment decoder directly; 4'hF is the decoder's blank code.
// A one-cycle change pulse and a BCD (0..9) change counter are also provided.
//
// Timing from a new x held steady (edges counted from its first sampling edge):
//   edge 1 s1, edge 2 s2, edge 3 cand, edge 3+DEBOUNCE_CYCLES stable,
//   edge 4+DEBOUNCE_CYCLES outputs and chg.
//
// There is no handshake on this block. en is a plain level enable for the
// output registers only; the synchronizer and debouncer always run.

module encode83_debounced #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DCNT_W          = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] x,
  output logic [2:0] y,
  output logic       valid,
  output logic [3:0] digit,
  output logic       chg,
  output logic [3:0] chg_cnt
);

  // Terminal debounce count: when cand has matched s2 on this many
  // consecutive edges after being loaded, the next matching edge accepts it.
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);

  // Synchronizer stages
  logic [7:0]        s1_q, s2_q;

  // Debouncer state
  logic [7:0]        cand_q, cand_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic [7:0]        stable_q, stable_d;

  // Priority encoder result (combinational on stable_q)
  logic [2:0]        y_n;
  logic              v_n;

  // Output registers
  logic [2:0]        y_q, y_d;
  logic              valid_q, valid_d;
  logic [3:0]        digit_q, digit_d;
  logic              chg_q, chg_d;
  logic [3:0]        chg_cnt_q, chg_cnt_d;

  // Two-flop synchronizer for the asynchronous switch vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= x;
      s2_q <= s1_q;
    end
  end

  // Debounce next state: any change of s2 restarts the window; a full window
  // of matches copies cand into stable, after which the counter parks at the
  // terminal value so stable keeps being refreshed with the same vector.
  always_comb begin
    cand_d   = cand_q;
    dcnt_d   = dcnt_q;
    stable_d = stable_q;
    if (s2_q != cand_q) begin
      cand_d = s2_q;
      dcnt_d = '0;
    end else if (dcnt_q == DCNT_LAST) begin
      stable_d = cand_q;
    end else begin
      dcnt_d = dcnt_q + DCNT_W'(1);
    end
  end

  // Debounce registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cand_q   <= '0;
      dcnt_q   <= '0;
      stable_q <= '0;
    end else begin
      cand_q   <= cand_d;
      dcnt_q   <= dcnt_d;
      stable_q <= stable_d;
    end
  end

  // Priority encode: ascending scan so the highest set bit wins; an all-zero
  // vector yields index 0 with v_n low.
  always_comb begin
    y_n = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (stable_q[i]) y_n = 3'(i);
    end
    v_n = |stable_q;
  end

  // Output next state: with en high, load the encoder result and pulse chg if
  // the encoded {valid, y} differs from what is currently presented; the BCD
  // counter advances on the same edge as the pulse. With en low everything
  // holds and chg drops, so changes while disabled collapse into one pulse
  // when en returns.
  always_comb begin
    y_d       = y_q;
    valid_d   = valid_q;
    digit_d   = digit_q;
    chg_d     = 1'b0;
    chg_cnt_d = chg_cnt_q;
    if (en) begin
      y_d     = y_n;
      valid_d = v_n;
      digit_d = v_n ? {1'b0, y_n} : 4'hF;
      chg_d   = ({v_n, y_n} != {valid_q, y_q});
      if (chg_d) begin
        chg_cnt_d = (chg_cnt_q == 4'd9) ? 4'd0 : chg_cnt_q + 4'd1;
      end
    end
  end

  // Output registers; reset overrides en.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q       <= 3'd0;
      valid_q   <= 1'b0;
      digit_q   <= 4'hF;
      chg_q     <= 1'b0;
      chg_cnt_q <= 4'd0;
    end else begin
      y_q       <= y_d;
      valid_q   <= valid_d;
      digit_q   <= digit_d;
      chg_q     <= chg_d;
      chg_cnt_q <= chg_cnt_d;
    end
  end

  assign y       = y_q;
  assign valid   = valid_q;
  assign digit   = digit_q;
  assign chg     = chg_q;
  assign chg_cnt = chg_cnt_q;

endmodule

// File: tb/tb_encode83_debounced.sv
// Bench for encode83_debounced: directed scenarios followed by randomized
// switch activity, every edge compared with a behavioural reference model.
module tb_encode83_debounced;

  localparam int D = 4;
  localparam int W = 13;  // {y[2:0], valid, digit[3:0], chg, chg_cnt[3:0]}

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] x;
  logic [2:0] y;
  logic       valid;
  logic [3:0] digit;
  logic       chg;
  logic [3:0] chg_cnt;

  int total = 0;
  int bad   = 0;

  // Scoreboard: the model pushes what it expects after each edge, the
  // checker pops it.
  logic [W-1:0] exp_q[$];

  // Reference model state
  logic [7:0] m_s1, m_s2;   // the two-sample delay of the synchronizer
  logic [7:0] run_val;      // value of the current run of identical s2 samples
  int         run_len;      // length of that run
  logic [7:0] m_stable;
  logic [2:0] m_y;
  logic       m_valid;
  logic       m_chg;
  int         m_cnt;

  encode83_debounced #(.DEBOUNCE_CYCLES(D), .DCNT_W(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .x       (x),
    .y       (y),
    .valid   (valid),
    .digit   (digit),
    .chg     (chg),
    .chg_cnt (chg_cnt)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Highest set bit index of a vector (0 when empty).
  function automatic logic [2:0] top_bit(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) begin
        r = 3'(i);
        break;
      end
    end
    return r;
  endfunction

  // Advance the model by one rising edge given the inputs present at it.
  task automatic model_edge(input logic [7:0] xv, input logic env, input logic rstv);
    logic [2:0] ny;
    logic       nv;
    logic [3:0] md;
    if (rstv) begin
      m_s1 = 8'h00; m_s2 = 8'h00;
      run_val = 8'h00; run_len = 1;
      m_stable = 8'h00;
      m_y = 3'd0; m_valid = 1'b0; m_chg = 1'b0; m_cnt = 0;
    end else begin
      ny = top_bit(m_stable);
      nv = (m_stable != 8'h00);
      if (env) begin
        m_chg = (nv != m_valid) || (ny != m_y);
        m_y = ny;
        m_valid = nv;
        if (m_chg) m_cnt = (m_cnt + 1) % 10;
      end else begin
        m_chg = 1'b0;
      end
      // A synchronized value is accepted once D+1 identical samples are seen.
      if (m_s2 == run_val) run_len = run_len + 1;
      else begin
        run_val = m_s2;
        run_len = 1;
      end
      if (run_len >= D + 1) m_stable = run_val;
      m_s2 = m_s1;
      m_s1 = xv;
    end
    md = m_valid ? {1'b0, m_y} : 4'hF;
    exp_q.push_back({m_y, m_valid, md, m_chg, 4'(m_cnt)});
  endtask

  // Single comparison point.
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare all outputs against the next scoreboard entry.
  task automatic check_outputs();
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = exp_q.pop_front();
      chk("outputs", 16'({y, valid, digit, chg, chg_cnt}), 16'(e));
    end
  endtask

  // Driver: apply inputs, take one edge, update model, sample 1 time unit later.
  task automatic step(input logic [7:0] xv, input logic env, input logic rstv);
    x = xv; en = env; rst = rstv;
    @(posedge clk);
    model_edge(xv, env, rstv);
    #1;
    check_outputs();
  endtask

  int         saw_chg;
  int         saw_seven;
  logic [3:0] cnt_before;
  logic [7:0] rx;
  int         hold;
  logic       ren;

  initial begin
    x = 8'h00; en = 1'b1; rst = 1'b1;

    // Reset and idle
    step(8'h00, 1'b1, 1'b1);
    step(8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      step(8'h00, 1'b1, 1'b0);
      chk("idle_digit", 16'(digit), 16'hF);
    end

    // 0 -> 8'h24: outputs move on the 8th edge
    for (int k = 1; k <= 12; k++) begin
      step(8'h24, 1'b1, 1'b0);
      if (k == 7) chk("pre_accept_valid", 16'(valid), 16'h0);
      if (k == 8) begin
        chk("accept_y", 16'(y), 16'h5);
        chk("accept_digit", 16'(digit), 16'h5);
        chk("accept_chg", 16'(chg), 16'h1);
        chk("accept_cnt", 16'(chg_cnt), 16'h1);
      end
      if (k == 9) chk("chg_one_cycle", 16'(chg), 16'h0);
    end

    // Back to idle, then a 3-cycle glitch of 8'h80
    for (int i = 0; i < 12; i++) step(8'h00, 1'b1, 1'b0);
    saw_chg = 0;
    for (int i = 0; i < 3; i++) begin
      step(8'h80, 1'b1, 1'b0);
      if (chg) saw_chg++;
    end
    for (int i = 0; i < 12; i++) begin
      step(8'h00, 1'b1, 1'b0);
      if (chg) saw_chg++;
    end
    chk("glitch_no_chg", 16'(saw_chg), 16'h0);
    chk("glitch_valid", 16'(valid), 16'h0);

    // 5-cycle pulse of 8'h80 is accepted
    saw_seven = 0;
    for (int i = 0; i < 5; i++) begin
      step(8'h80, 1'b1, 1'b0);
      if (y == 3'd7 && digit == 4'h7) saw_seven++;
    end
    for (int i = 0; i < 12; i++) begin
      step(8'h00, 1'b1, 1'b0);
      if (y == 3'd7 && digit == 4'h7) saw_seven++;
    end
    chk("pulse5_accepted", 16'(saw_seven > 0), 16'h1);

    // 8'h81 -> 8'h80 gives no pulse; then 8'h01 gives exactly one
    for (int i = 0; i < 12; i++) step(8'h81, 1'b1, 1'b0);
    chk("y_81", 16'(y), 16'h7);
    saw_chg = 0;
    for (int i = 0; i < 12; i++) begin
      step(8'h80, 1'b1, 1'b0);
      if (chg) saw_chg++;
    end
    chk("same_code_no_chg", 16'(saw_chg), 16'h0);
    chk("y_80", 16'(y), 16'h7);
    saw_chg = 0;
    for (int i = 0; i < 12; i++) begin
      step(8'h01, 1'b1, 1'b0);
      if (chg) saw_chg++;
    end
    chk("y_01", 16'(y), 16'h0);
    chk("digit_01", 16'(digit), 16'h0);
    chk("chg_01_once", 16'(saw_chg), 16'h1);

    // Disabled while x goes 8'h02 -> 8'h10
    cnt_before = chg_cnt;
    saw_chg = 0;
    for (int i = 0; i < 6; i++) begin
      step(8'h02, 1'b0, 1'b0);
      if (chg) saw_chg++;
    end
    for (int i = 0; i < 12; i++) begin
      step(8'h10, 1'b0, 1'b0);
      if (chg) saw_chg++;
    end
    chk("frozen_no_chg", 16'(saw_chg), 16'h0);
    chk("frozen_y", 16'(y), 16'h0);
    chk("frozen_cnt", 16'(chg_cnt), 16'(cnt_before));
    step(8'h10, 1'b1, 1'b0);
    chk("reenable_y", 16'(y), 16'h4);
    chk("reenable_chg", 16'(chg), 16'h1);
    chk("reenable_cnt", 16'(chg_cnt), 16'((cnt_before + 4'd1) % 4'd10));
    step(8'h10, 1'b1, 1'b0);
    chk("reenable_single", 16'(chg), 16'h0);

    // Eleven alternating accepted changes exercise the BCD wrap
    for (int n = 0; n < 11; n++) begin
      for (int i = 0; i < 8; i++) step((n % 2 == 0) ? 8'h01 : 8'h02, 1'b1, 1'b0);
    end

    // Reset in the middle of a debounce window
    for (int i = 0; i < 4; i++) step(8'h80, 1'b1, 1'b0);
    step(8'h80, 1'b0, 1'b1);
    chk("rst_y", 16'(y), 16'h0);
    chk("rst_valid", 16'(valid), 16'h0);
    chk("rst_digit", 16'(digit), 16'hF);
    chk("rst_chg", 16'(chg), 16'h0);
    chk("rst_cnt", 16'(chg_cnt), 16'h0);
    for (int i = 0; i < 10; i++) step(8'h00, 1'b1, 1'b0);

    // Randomized activity with variable hold lengths, enable gaps and resets
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 3))
        0: rx = 8'h00;
        1: rx = 8'h01 << $urandom_range(0, 7);
        default: rx = 8'($urandom);
      endcase
      hold = $urandom_range(1, 9);
      ren = ($urandom_range(0, 5) != 0);
      for (int i = 0; i < hold; i++) step(rx, ren, ($urandom_range(0, 199) == 0));
    end
    for (int i = 0; i < 12; i++) step(8'h00, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
